// File: rtl/strobe_link_pkg.sv
// Shared types and limits for the bit-strobe link.
// STROBE_SER_PARITY_EN adds the PAR state used by the parity extension.
package strobe_link_pkg;

  localparam int unsigned STROBE_MAX_WIDTH = 32;
  localparam int unsigned STROBE_MAX_GAP   = 15;
  localparam int unsigned STROBE_GAP_W     = $clog2(STROBE_MAX_GAP + 1);

`ifdef STROBE_SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, BIT, WAIT, FIN, PAR} strobe_state_t;
`else
  typedef enum logic [2:0] {IDLE, BIT, WAIT, FIN} strobe_state_t;
`endif

endpackage

// File: rtl/strobe_gap_cnt.sv
// Loadable down-counter timing the idle gap after each strobed bit.
// expired is high in the final gap cycle (count reached zero).
module strobe_gap_cnt
  import strobe_link_pkg::*;
#(
  parameter int unsigned W = STROBE_GAP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/strobe_ser_tx.sv
// Parallel-to-serial transmitter driving the ser_d/ser_s hold/load link.
// Define STROBE_SER_PARITY_EN to append an even-parity bit to every word.
module strobe_ser_tx
  import strobe_link_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GAP       = 0,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_d,
  output logic             ser_s,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [STROBE_GAP_W-1:0] GAP_LOAD =
    (GAP > 0) ? STROBE_GAP_W'(GAP - 1) : '0;

  strobe_state_t    state, state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             accept, advance;
  logic             strobing, next_strobing;
  logic             gap_expired;
`ifdef STROBE_SER_PARITY_EN
  logic             par_bit, par_sent;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  assign in_ready = (state == IDLE) && rst_n;

  strobe_gap_cnt #(.W(STROBE_GAP_W)) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (strobing),
    .load_val (GAP_LOAD),
    .en       (state == WAIT),
    .expired  (gap_expired)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = BIT;
          accept     = 1'b1;
        end
      end
      BIT: begin
        if (GAP > 0) begin
          state_next = WAIT;
        end else if (last_bit) begin
`ifdef STROBE_SER_PARITY_EN
          state_next = PAR;
`else
          state_next = FIN;
`endif
        end else begin
          state_next = BIT;
          advance    = 1'b1;
        end
      end
      WAIT: begin
        if (gap_expired) begin
          if (last_bit) begin
`ifdef STROBE_SER_PARITY_EN
            state_next = par_sent ? FIN : PAR;
`else
            state_next = FIN;
`endif
          end else begin
            state_next = BIT;
            advance    = 1'b1;
          end
        end
      end
`ifdef STROBE_SER_PARITY_EN
      PAR: state_next = (GAP > 0) ? WAIT : FIN;
`endif
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    strobing      = (state == BIT);
    next_strobing = (state_next == BIT);
`ifdef STROBE_SER_PARITY_EN
    if (state == PAR)      strobing      = 1'b1;
    if (state_next == PAR) next_strobing = 1'b1;
`endif
  end

  // Outputs are registered from state_next so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      ser_d   <= 1'b0;
      ser_s   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef STROBE_SER_PARITY_EN
      par_bit  <= 1'b0;
      par_sent <= 1'b0;
`endif
    end else begin
      state <= state_next;
      ser_s <= next_strobing;
      busy  <= (state_next != IDLE) && (state_next != FIN);
      done  <= (state_next == FIN);
      if (accept) begin
        ser_d   <= head_bit(in_data);
        shreg   <= shift_out(in_data);
        bit_cnt <= '0;
      end else if (advance) begin
        ser_d   <= head_bit(shreg);
        shreg   <= shift_out(shreg);
        bit_cnt <= bit_cnt + CW'(1);
      end
`ifdef STROBE_SER_PARITY_EN
      else if ((state_next == PAR) && (state != PAR)) begin
        ser_d <= par_bit;
      end
      if (accept) begin
        par_bit  <= ^in_data;
        par_sent <= 1'b0;
      end else if (state == PAR) begin
        par_sent <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_strobe_ser_tx.sv
// Directed bench for strobe_ser_tx: three instances (GAP=0 MSB-first,
// GAP=2 MSB-first, GAP=0 LSB-first); honours STROBE_SER_PARITY_EN.
module tb_strobe_ser_tx;

`ifdef STROBE_SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int WN = 8 + PB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] iv, ir, sd, ss, by, dn;
  logic [7:0] idat [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  strobe_ser_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(idat[0]), .in_ready(ir[0]),
    .ser_d(sd[0]), .ser_s(ss[0]), .busy(by[0]), .done(dn[0]));
  strobe_ser_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(idat[1]), .in_ready(ir[1]),
    .ser_d(sd[1]), .ser_s(ss[1]), .busy(by[1]), .done(dn[1]));
  strobe_ser_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_data(idat[2]), .in_ready(ir[2]),
    .ser_d(sd[2]), .ser_s(ss[2]), .busy(by[2]), .done(dn[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Send one word on unit u; seq holds strobed bits in arrival order (first at the top).
  task automatic send_word(input int u, input logic [7:0] w, input int sp,
                           output logic [15:0] seq, output int ns, output int first_c,
                           output int done_c, output int hold_err, output int sp_err);
    int   t;
    int   last_c;
    logic pd;
    t = 0; seq = '0; ns = 0; first_c = -1; done_c = -1;
    hold_err = 0; sp_err = 0; last_c = 0; pd = 1'b0;
    @(negedge clk);
    while (!ir[u] && t < 40) begin
      @(negedge clk);
      t++;
    end
    iv[u] = 1'b1; idat[u] = w;
    @(posedge clk);
    #1;
    iv[u] = 1'b0; idat[u] = ~w;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 3) idat[u] = w ^ 8'h5A;
      if (ss[u]) begin
        seq = {seq[14:0], sd[u]};
        if (ns == 0) first_c = c;
        else if (c - last_c != sp) sp_err++;
        last_c = c;
        ns++;
      end else if (ns > 0 && sd[u] !== pd) begin
        hold_err++;
      end
      pd = sd[u];
      if (dn[u]) begin
        done_c = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] seq;
    int          ns, fc, dc, he, se, widx, scnt;
    logic [7:0]  words [2];
    logic [7:0]  w1, w2;
    logic        bq [$];
    int          sc [$];

    rst_n = 1'b0; iv = '0;
    idat[0] = '0; idat[1] = '0; idat[2] = '0;
    repeat (2) @(negedge clk);
    check("rst_ser_s", 32'(ss), 32'h0);
    check("rst_ser_d", 32'(sd), 32'h0);
    check("rst_busy", 32'(by), 32'h0);
    check("rst_done", 32'(dn), 32'h0);
    check("rst_in_ready", 32'(ir), 32'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(ir), 32'h7);

    // 0xA5, GAP=0, MSB first: 1,0,1,0,0,1,0,1 on consecutive strobes
    send_word(0, 8'hA5, 1, seq, ns, fc, dc, he, se);
    check("a5_bits", 32'(seq[PB+7:PB]), 32'hA5);
    check("a5_nstrobe", 32'(ns), 32'(WN));
    check("a5_first", 32'(fc), 32'd0);
    check("a5_done_cycle", 32'(dc), 32'(WN));
    check("a5_hold", 32'(he), 32'd0);
    check("a5_spacing", 32'(se), 32'd0);
    check("a5_busy_at_done", 32'(by[0]), 32'd0);
    check("a5_ready_at_done", 32'(ir[0]), 32'd0);
`ifdef STROBE_SER_PARITY_EN
    check("a5_parity", 32'(seq[0]), 32'd0);
`endif
    @(negedge clk);
    check("a5_ready_after", 32'(ir[0]), 32'd1);

    // 0x81 with GAP=2: strobe every 3 cycles, done 24 cycles after first strobe
    send_word(1, 8'h81, 3, seq, ns, fc, dc, he, se);
    check("gap_bits", 32'(seq[PB+7:PB]), 32'h81);
    check("gap_nstrobe", 32'(ns), 32'(WN));
    check("gap_first", 32'(fc), 32'd0);
    check("gap_done_cycle", 32'(dc), 32'(WN * 3));
    check("gap_hold", 32'(he), 32'd0);
    check("gap_spacing", 32'(se), 32'd0);

    // 0x01 LSB first: arrival order 1 then seven 0s
    send_word(2, 8'h01, 1, seq, ns, fc, dc, he, se);
    check("lsb_bits", 32'(seq[PB+7:PB]), 32'h80);
    check("lsb_nstrobe", 32'(ns), 32'(WN));
    check("lsb_done_cycle", 32'(dc), 32'(WN));
`ifdef STROBE_SER_PARITY_EN
    check("lsb_parity", 32'(seq[0]), 32'd1);
`endif

    // Back-to-back 0x3C, 0xC3 with in_valid held; in_data scrambled while busy
    words[0] = 8'h3C; words[1] = 8'hC3; widx = 0;
    @(negedge clk);
    iv[0] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (ss[0]) begin
        bq.push_back(sd[0]);
        sc.push_back(c);
      end
      if (ir[0]) begin
        if (widx < 2) begin
          idat[0] = words[widx];
          widx++;
        end else begin
          iv[0] = 1'b0;
        end
      end else begin
        idat[0] = 8'($urandom);
      end
      @(negedge clk);
    end
    iv[0] = 1'b0;
    check("b2b_nstrobe", 32'(bq.size()), 32'(2 * WN));
    w1 = '0; w2 = '0;
    if (bq.size() >= 2 * WN) begin
      for (int i = 0; i < 8; i++) begin
        w1 = {w1[6:0], bq[i]};
        w2 = {w2[6:0], bq[WN + i]};
      end
    end
    check("b2b_word1", 32'(w1), 32'h3C);
    check("b2b_word2", 32'(w2), 32'hC3);
    check("b2b_gap", (sc.size() > WN) ? 32'(sc[WN] - sc[WN-1]) : 32'hFFFF, 32'd3);

    // Reset after the third strobe of 0xFF
    @(negedge clk);
    iv[0] = 1'b1; idat[0] = 8'hFF;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    scnt = 0;
    for (int c = 0; c < 20 && scnt < 3; c++) begin
      @(negedge clk);
      if (ss[0]) scnt++;
    end
    check("rstmid_saw3", 32'(scnt), 32'd3);
    rst_n = 1'b0;
    #1;
    check("rstmid_ser_s", 32'(ss[0]), 32'd0);
    check("rstmid_ser_d", 32'(sd[0]), 32'd0);
    check("rstmid_busy", 32'(by[0]), 32'd0);
    check("rstmid_done", 32'(dn[0]), 32'd0);
    check("rstmid_ready", 32'(ir[0]), 32'd0);
    scnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (ss != '0) scnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ss != '0) scnt++;
    end
    check("rstmid_no_strobes", 32'(scnt), 32'd0);
    check("rstmid_ready_after", 32'(ir[0]), 32'd1);
    send_word(0, 8'h5A, 1, seq, ns, fc, dc, he, se);
    check("rstmid_5a_bits", 32'(seq[PB+7:PB]), 32'h5A);
    check("rstmid_5a_nstrobe", 32'(ns), 32'(WN));

`ifdef STROBE_SER_PARITY_EN
    send_word(0, 8'h07, 1, seq, ns, fc, dc, he, se);
    check("p07_bits", 32'(seq[8:1]), 32'h07);
    check("p07_parity", 32'(seq[0]), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
